// File: rtl/boot_ctrl_if.sv
// Host register bus between the regbus master and the boot controller.
// Writes are single-cycle strobes. Reads return data one cycle after RDEN.
interface boot_ctrl_if;
    logic [15:0] WRADDR;
    logic [3:0]  BYTEEN;
    logic        WREN;
    logic [31:0] WDATA;
    logic [15:0] RDADDR;
    logic        RDEN;
    logic [31:0] RDATA;

    modport master (
        output WRADDR, BYTEEN, WREN, WDATA, RDADDR, RDEN,
        input  RDATA
    );

    modport slave (
        input  WRADDR, BYTEEN, WREN, WDATA, RDADDR, RDEN,
        output RDATA
    );
endinterface

// File: rtl/boot_ctrl.sv
// Boot controller: holds the RV32 core in reset, then sequences its release on START.
// Latches the boot addresses, records the halt exit code, and counts run cycles for the host.
module boot_ctrl #(
    parameter logic [15:0] BASE_ADDR    = 16'h1000,
    parameter int          RST_CYCLES   = 16,
    parameter logic [31:0] DRAMBASE_RST = 32'h0,
    parameter logic [31:0] ENTRYPC_RST  = 32'h0
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    boot_ctrl_if.slave        bus,
    output logic              cpu_rst_n,
    output logic [31:0]       dram_base,
    output logic [31:0]       entry_pc,
    input  logic              cpu_halt,
    input  logic [31:0]       cpu_exit_code
);

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_RUN    = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam int                CNT_W      = $clog2(RST_CYCLES + 2);
    localparam logic [CNT_W-1:0]  PRIME_LAST = CNT_W'(RST_CYCLES);

    localparam logic [4:0] OFF_STATUS   = 5'h00;
    localparam logic [4:0] OFF_CTRL     = 5'h04;
    localparam logic [4:0] OFF_DRAMBASE = 5'h08;
    localparam logic [4:0] OFF_ENTRYPC  = 5'h0C;
    localparam logic [4:0] OFF_EXITCODE = 5'h10;
    localparam logic [4:0] OFF_RUNCYC   = 5'h14;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return r;
    endfunction

    state_t            state;
    logic [CNT_W-1:0]  prime_cnt;
    logic              hold_reset;
    logic [31:0]       drambase_q;
    logic [31:0]       entrypc_q;
    logic [31:0]       exitcode_q;
    logic [31:0]       runcyc_q;
    logic [31:0]       rd_mux;

    // Unsigned subtraction folds the below-base case into the upper-bound test.
    logic [15:0] wr_off_full;
    logic [15:0] rd_off_full;
    logic        wr_hit;
    logic        rd_hit;
    logic [4:0]  wr_off;
    logic [4:0]  rd_off;

    assign wr_off_full = bus.WRADDR - BASE_ADDR;
    assign rd_off_full = bus.RDADDR - BASE_ADDR;
    assign wr_hit      = bus.WREN && (wr_off_full <= 16'h001F);
    assign rd_hit      = rd_off_full <= 16'h001F;
    assign wr_off      = wr_off_full[4:0];
    assign rd_off      = rd_off_full[4:0];

    logic ctrl_wr;
    logic hold_cmd;
    logic start_cmd;

    assign ctrl_wr   = wr_hit && (wr_off == OFF_CTRL) && bus.BYTEEN[0];
    assign hold_cmd  = ctrl_wr && bus.WDATA[0];
    assign start_cmd = ctrl_wr && !bus.WDATA[0] && bus.WDATA[1];

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state      <= ST_HOLD;
            cpu_rst_n  <= 1'b0;
            hold_reset <= 1'b1;
            prime_cnt  <= '0;
            dram_base  <= DRAMBASE_RST;
            entry_pc   <= ENTRYPC_RST;
            exitcode_q <= '0;
            runcyc_q   <= '0;
        end else begin
            case (state)
                ST_PRIME: begin
                    if (prime_cnt == PRIME_LAST) begin
                        state     <= ST_RUN;
                        cpu_rst_n <= 1'b1;
                    end else begin
                        prime_cnt <= prime_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    runcyc_q <= sat_inc(runcyc_q);
                    if (cpu_halt) begin
                        exitcode_q <= cpu_exit_code;
                        state      <= ST_HALTED;
                        cpu_rst_n  <= 1'b0;
                    end
                end
                default: ;
            endcase

            if (ctrl_wr)
                hold_reset <= bus.WDATA[0];

            // A HOLD request overrides both START and a same-cycle halt transition.
            if (hold_cmd) begin
                state     <= ST_HOLD;
                cpu_rst_n <= 1'b0;
            end else if (start_cmd && (state == ST_HOLD || state == ST_HALTED)) begin
                state      <= ST_PRIME;
                prime_cnt  <= '0;
                dram_base  <= drambase_q;
                entry_pc   <= entrypc_q;
                runcyc_q   <= '0;
                exitcode_q <= '0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            drambase_q <= DRAMBASE_RST;
            entrypc_q  <= ENTRYPC_RST;
        end else begin
            if (wr_hit && wr_off == OFF_DRAMBASE)
                drambase_q <= lane_merge(drambase_q, bus.WDATA, bus.BYTEEN);
            if (wr_hit && wr_off == OFF_ENTRYPC)
                entrypc_q <= lane_merge(entrypc_q, bus.WDATA, bus.BYTEEN);
        end
    end

    always_comb begin
        rd_mux = 32'h0;
        if (rd_hit) begin
            case (rd_off)
                OFF_STATUS:   rd_mux = {26'd0, state, (state == ST_PRIME), (state == ST_HALTED),
                                        ~cpu_rst_n, (state == ST_RUN)};
                OFF_CTRL:     rd_mux = {31'd0, hold_reset};
                OFF_DRAMBASE: rd_mux = drambase_q;
                OFF_ENTRYPC:  rd_mux = entrypc_q;
                OFF_EXITCODE: rd_mux = exitcode_q;
                OFF_RUNCYC:   rd_mux = runcyc_q;
                default:      rd_mux = 32'h0;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)
            bus.RDATA <= '0;
        else if (bus.RDEN)
            bus.RDATA <= rd_mux;
    end

endmodule
